mem_arbiter: RTL

Two-port arbiter and sequencer that shares one unified single-port memory between the instruction-fetch path and the load/store path of the RV32I core. It replaces the separate instruction and data memories with one memory behind a request/grant/done handshake. It sits between the PC/fetch logic and the ALU-address/data path on one side, and the memory macro on the other. One transaction is outstanding at a time, with round-robin arbitration on conflicts.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction-fetch (IF) port and
// the load/store (LS) port. Only one transaction is in flight at a time. When
// both ports request together, the port that was not granted most recently
// wins.
//
// Transaction flow:
//   IDLE/RESP -> CMD -> (WAIT x MEM_LAT) -> RESP   for reads
//   IDLE/RESP -> CMD -> RESP                       for stores
//
// Parameters:
//   MEM_LAT   memory read latency in cycles, from the mem_en cycle until
//             mem_rdata is valid (1..8)
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   if_req, if_addr           fetch request (level) and byte address
//   if_gnt, if_done           one-cycle pulses: fetch accepted / data valid
//   if_rdata                  fetched word, held until the next if_done
//   ls_req, ls_we             load/store request (level), 1 = store
//   ls_addr, ls_wdata         load/store byte address and store data
//   ls_gnt, ls_done           one-cycle pulses: accepted / complete
//   ls_rdata                  load data, held until the next load completes
//   mem_en, mem_we            memory command strobe and write enable
//   mem_addr, mem_wdata       memory address and write data (held when idle)
//   mem_rdata                 memory read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RESP
  } state_t;

  // The WAIT counter runs from MEM_LAT-1 down to 0, so its last value marks
  // the cycle in which mem_rdata is valid.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       last_ls;
  logic       cur_ls;
  logic       cur_we;
  logic       any_req;
  logic       pick_ls;

  // Round-robin choice: LS wins alone, or on a tie when IF was granted last.
  assign any_req = if_req | ls_req;
  assign pick_ls = ls_req & (~if_req | ~last_ls);

  // Single sequencer: state, pointer, counter and every output are registered
  // here so no request input reaches a grant combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      last_ls   <= 1'b1;
      cur_ls    <= 1'b0;
      cur_we    <= 1'b0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= 32'd0;
      ls_gnt    <= 1'b0;
      ls_done   <= 1'b0;
      ls_rdata  <= 32'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      // Pulses default low; each state raises only the ones it owns.
      if_gnt  <= 1'b0;
      ls_gnt  <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;

      case (state)
        // Requests are only looked at here, which lets RESP start the next
        // transaction without an idle bubble.
        IDLE, RESP: begin
          if (any_req) begin
            state   <= CMD;
            mem_en  <= 1'b1;
            cur_ls  <= pick_ls;
            last_ls <= pick_ls;
            if (pick_ls) begin
              ls_gnt    <= 1'b1;
              cur_we    <= ls_we;
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
            end else begin
              if_gnt    <= 1'b1;
              cur_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= 32'd0;
            end
          end else begin
            state <= IDLE;
          end
        end

        // The command went out this cycle; stores complete right away.
        CMD: begin
          if (cur_we) begin
            state   <= RESP;
            ls_done <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end

        // Capture the read data on the final wait cycle.
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
            if (cur_ls) begin
              ls_rdata <= mem_rdata;
              ls_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
